// File: rtl/stream_demux_if.sv
// Valid/ready bundle for stream_demux: one producer port and two consumer ports with occupancy.
// The slave modport is the demux itself; the master modport is the producer/consumer side.
interface stream_demux_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 2
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CW-1:0]    out1_count;

  logic [WIDTH-1:0] out2_data;
  logic             out2_valid;
  logic             out2_ready;
  logic [CW-1:0]    out2_count;

  modport slave (
    input  in_data, in_sel, in_valid, out1_ready, out2_ready,
    output in_ready, out1_data, out1_valid, out1_count,
           out2_data, out2_valid, out2_count
  );

  modport master (
    output in_data, in_sel, in_valid, out1_ready, out2_ready,
    input  in_ready, out1_data, out1_valid, out1_count,
           out2_data, out2_valid, out2_count
  );
endinterface

// File: rtl/stream_demux.sv
// 1-to-2 stream router: in_sel=1 steers a beat to out1, in_sel=0 to out2,
// each output backed by its own DEPTH-entry FIFO.
module stream_demux #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input logic          clk,
  input logic          rst,
  stream_demux_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  // Index 0 is out1, index 1 is out2.
  logic [1:0]       out_ready;
  logic [1:0]       full;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [CW-1:0]    count [2];
  logic [WIDTH-1:0] head  [2];
  logic             accept;

  assign out_ready = {bus.out2_ready, bus.out1_ready};

  // No pass-through: a full FIFO refuses its beat even if it is popping this cycle.
  assign bus.in_ready = ~rst & ~(bus.in_sel ? full[0] : full[1]);
  assign accept       = bus.in_valid & bus.in_ready;
  assign push         = {accept & ~bus.in_sel, accept & bus.in_sel};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [WIDTH-1:0] mem [DEPTH];
      logic [AW-1:0]    wr_ptr_reg;
      logic [AW-1:0]    rd_ptr_reg;
      logic [CW-1:0]    count_reg;

      assign full[gi]  = (count_reg == CW'(DEPTH));
      assign pop[gi]   = (count_reg != '0) & out_ready[gi];
      assign count[gi] = count_reg;
      assign head[gi]  = (count_reg != '0) ? mem[rd_ptr_reg] : '0;

      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem[wr_ptr_reg] <= bus.in_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push[gi]) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
          end
          if (pop[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
          end
          case ({push[gi], pop[gi]})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  assign bus.out1_data  = head[0];
  assign bus.out1_valid = (count[0] != '0);
  assign bus.out1_count = count[0];
  assign bus.out2_data  = head[1];
  assign bus.out2_valid = (count[1] != '0);
  assign bus.out2_count = count[1];
endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed scenarios plus randomized traffic against a queue model.
module tb_stream_demux;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] q2[$];

  stream_demux_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  stream_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model one clock edge from the currently driven inputs, then settle past the edge.
  task automatic step();
    bit acc, p1, p2;
    acc = !rst && bus.in_valid &&
          (bus.in_sel ? (q1.size() < DEPTH) : (q2.size() < DEPTH));
    p1 = bus.out1_ready && (q1.size() > 0);
    p2 = bus.out2_ready && (q2.size() > 0);
    @(posedge clk);
    if (rst) begin
      q1.delete();
      q2.delete();
    end else begin
      if (p1) void'(q1.pop_front());
      if (p2) void'(q2.pop_front());
      if (acc) begin
        if (bus.in_sel) q1.push_back(bus.in_data);
        else            q2.push_back(bus.in_data);
      end
    end
    $display("cycle: rst=%0b v=%0b sel=%0b d=%h | o1 v=%0b c=%0d d=%h | o2 v=%0b c=%0d d=%h",
             rst, bus.in_valid, bus.in_sel, bus.in_data,
             bus.out1_valid, bus.out1_count, bus.out1_data,
             bus.out2_valid, bus.out2_count, bus.out2_data);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_sel     = 1'b0;
    bus.in_data    = '0;
    bus.out1_ready = 1'b0;
    bus.out2_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out1_valid !== 1'b0 || bus.out2_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b%b want 00", bus.out1_valid, bus.out2_valid);
    end
    checks++;
    if (bus.out1_data !== '0 || bus.out2_data !== '0) begin
      errors++;
      $display("FAIL reset_data got %h %h want 0 0", bus.out1_data, bus.out2_data);
    end
    checks++;
    if (bus.out1_count !== '0 || bus.out2_count !== '0) begin
      errors++;
      $display("FAIL reset_count got %0d %0d want 0 0", bus.out1_count, bus.out2_count);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_single_route();
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b1;
    bus.in_data  = 32'hDEADBEEF;
    step();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'hDEADBEEF || bus.out1_count !== 2'd1) begin
      errors++;
      $display("FAIL single_out1 got v=%b d=%h c=%0d want v=1 d=deadbeef c=1",
               bus.out1_valid, bus.out1_data, bus.out1_count);
    end
    checks++;
    if (bus.out2_valid !== 1'b0 || bus.out2_data !== '0) begin
      errors++;
      $display("FAIL single_out2 got v=%b d=%h want v=0 d=0", bus.out2_valid, bus.out2_data);
    end
    bus.out1_ready = 1'b1;
    step();
    bus.out1_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b1;
    bus.in_data  = 32'h11;
    step();
    bus.in_data  = 32'h22;
    step();
    bus.in_data  = 32'h99;
    #1;
    checks++;
    if (bus.out1_count !== 2'd2 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full got c=%0d rdy=%b want c=2 rdy=0", bus.out1_count, bus.in_ready);
    end
    bus.in_sel  = 1'b0;
    bus.in_data = 32'h33;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_other_ready got %b want 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out2_valid !== 1'b1 || bus.out2_data !== 32'h33 ||
        bus.out1_count !== 2'd2 || bus.out1_data !== 32'h11) begin
      errors++;
      $display("FAIL bp_out2 got o2v=%b o2d=%h o1c=%0d o1d=%h want 1 33 2 11",
               bus.out2_valid, bus.out2_data, bus.out1_count, bus.out1_data);
    end
    bus.out1_ready = 1'b1;
    bus.out2_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.out1_ready = 1'b0;
    bus.out2_ready = 1'b0;
  endtask

  task automatic test_drain_wrap();
    logic [WIDTH-1:0] got[$];
    int idx = 0;
    int cyc = 0;
    bit over = 0;
    bus.in_sel = 1'b0;
    while ((idx < 5 || got.size() < 5) && cyc < 40) begin
      bus.out2_ready = (cyc % 2 == 0);
      bus.in_valid   = (idx < 5);
      bus.in_data    = WIDTH'(idx + 1);
      #1;
      if (bus.out2_valid && bus.out2_ready) got.push_back(bus.out2_data);
      if (bus.in_valid && bus.in_ready) idx++;
      step();
      if (bus.out2_count > 2'd2) over = 1;
      cyc++;
    end
    idle_inputs();
    checks++;
    if (over || cyc >= 40) begin
      errors++;
      $display("FAIL wrap_bound got over=%0b cycles=%0d want over=0 cycles<40", over, cyc);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== WIDTH'(i + 1)) begin
        errors++;
        $display("FAIL wrap_order[%0d] got %h want %h", i,
                 (i < got.size()) ? got[i] : 'x, WIDTH'(i + 1));
      end
    end
  endtask

  task automatic test_push_pop();
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b1;
    bus.in_data  = 32'hA;
    step();
    bus.in_data    = 32'hB;
    bus.out1_ready = 1'b1;
    step();
    bus.in_valid   = 1'b0;
    bus.out1_ready = 1'b0;
    #1;
    checks++;
    if (bus.out1_count !== 2'd1 || bus.out1_data !== 32'hB) begin
      errors++;
      $display("FAIL push_pop got c=%0d d=%h want c=1 d=b", bus.out1_count, bus.out1_data);
    end
    bus.out1_ready = 1'b1;
    step();
    bus.out1_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_sel  = (i < 2);
      bus.in_data = WIDTH'(32'h50 + i);
      step();
    end
    #1;
    checks++;
    if (bus.out1_count !== 2'd2 || bus.out2_count !== 2'd2) begin
      errors++;
      $display("FAIL rstmid_fill got %0d %0d want 2 2", bus.out1_count, bus.out2_count);
    end
    rst = 1'b1;
    bus.in_sel  = 1'b0;
    bus.in_data = 32'h77;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out1_count !== '0 || bus.out2_count !== '0 || bus.out1_valid !== 1'b0 ||
        bus.out2_valid !== 1'b0 || bus.out1_data !== '0 || bus.out2_data !== '0) begin
      errors++;
      $display("FAIL rstmid_clear got c=%0d/%0d v=%b%b d=%h/%h want all 0",
               bus.out1_count, bus.out2_count, bus.out1_valid, bus.out2_valid,
               bus.out1_data, bus.out2_data);
    end
    step();
    checks++;
    if (bus.out2_count !== '0) begin
      errors++;
      $display("FAIL rstmid_drop got c=%0d want 0", bus.out2_count);
    end
  endtask

  task automatic test_idle_pop();
    idle_inputs();
    bus.out2_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.out2_count !== '0 || bus.out2_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_pop[%0d] got c=%0d v=%b want 0 0", i, bus.out2_count, bus.out2_valid);
      end
    end
    bus.out2_ready = 1'b0;
  endtask

  task automatic test_random();
    bit hold = 0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 60) == 0);
      if (!hold) begin
        bus.in_sel  = $urandom_range(0, 1);
        bus.in_data = $urandom;
      end
      bus.in_valid   = hold || ($urandom_range(0, 3) != 0);
      bus.out1_ready = ($urandom_range(0, 2) == 0);
      bus.out2_ready = ($urandom_range(0, 1) == 0);
      #1;
      checks++;
      if (bus.in_ready !== (!rst && (bus.in_sel ? q1.size() < DEPTH : q2.size() < DEPTH))) begin
        errors++;
        $display("FAIL rand_in_ready[%0d] got %b want %b", n, bus.in_ready,
                 !rst && (bus.in_sel ? q1.size() < DEPTH : q2.size() < DEPTH));
      end
      hold = bus.in_valid && !bus.in_ready && !rst;
      step();
      checks++;
      if (bus.out1_count !== CW'(q1.size()) || bus.out1_valid !== (q1.size() > 0) ||
          bus.out1_data !== ((q1.size() > 0) ? q1[0] : '0)) begin
        errors++;
        $display("FAIL rand_out1[%0d] got c=%0d v=%b d=%h want c=%0d d=%h", n,
                 bus.out1_count, bus.out1_valid, bus.out1_data, q1.size(),
                 (q1.size() > 0) ? q1[0] : '0);
      end
      checks++;
      if (bus.out2_count !== CW'(q2.size()) || bus.out2_valid !== (q2.size() > 0) ||
          bus.out2_data !== ((q2.size() > 0) ? q2[0] : '0)) begin
        errors++;
        $display("FAIL rand_out2[%0d] got c=%0d v=%b d=%h want c=%0d d=%h", n,
                 bus.out2_count, bus.out2_valid, bus.out2_data, q2.size(),
                 (q2.size() > 0) ? q2[0] : '0);
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_route();
    test_backpressure();
    test_drain_wrap();
    test_push_pop();
    test_reset_mid();
    test_idle_pop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
